// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame geometry.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // One start bit, eight data bits, one stop bit.
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter. Writes into a full FIFO are
// dropped even when a pop happens on the same edge; full/empty are registered.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_next = cnt;
    case ({push_ok, pop_ok})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_next;
      full  <= (cnt_next == CW'(DEPTH));
      empty <= (cnt_next == '0);
    end
  end

  // Storage array; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO plus start/data/stop serialiser, 8N1, LSB first.
// TXD, busy and full are all registered outputs.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 20,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       TXD
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t                 state;
  tx_state_t                 state_next;
  logic [CNT_W-1:0]          bit_cnt;
  logic [CNT_W-1:0]          bit_cnt_next;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          bit_idx_next;
  logic [DATA_BITS-1:0]      shreg;
  logic [DATA_BITS-1:0]      shreg_next;
  logic [DATA_BITS-1:0]      head;
  logic                      txd_next;
  logic                      busy_next;
  logic                      pop;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state, pop request and next line level. TXD is registered from the
  // value it must carry in the new state, so the start bit appears in the
  // cycle right after the pop edge.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    txd_next     = TXD;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        txd_next = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shreg_next   = head;
          state_next   = START;
          bit_cnt_next = RELOAD;
          txd_next     = 1'b0;
        end
      end
      START: begin
        if (bit_cnt == '0) begin
          state_next   = DATA;
          bit_cnt_next = RELOAD;
          bit_idx_next = '0;
          txd_next     = shreg[0];
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt == '0) begin
          bit_cnt_next = RELOAD;
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            txd_next     = shreg[bit_idx + 1'b1];
          end
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt == '0) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop          = 1'b1;
            shreg_next   = head;
            state_next   = START;
            bit_cnt_next = RELOAD;
            txd_next     = 1'b0;
          end else begin
            state_next = IDLE;
            txd_next   = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // busy mirrors the post-edge state and occupancy. A pop always moves the FSM
  // out of IDLE, so only an accepted write can make an empty FIFO non-empty.
  always_comb begin
    busy_next = (state_next != IDLE) || (fifo_count != '0) || (wr_en && !full);
  end

  // State, baud counter, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      TXD     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      TXD     <= txd_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus randomized traffic, every cycle
// compared against a queue-and-frame-offset reference model.
module tb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FD    = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       CLK;
  logic       RESET;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       TXD;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queued bytes plus the byte on the wire and its cycle offset.
  logic [7:0]  mq[$];
  bit          m_active = 1'b0;
  int unsigned m_off    = 0;
  logic [7:0]  m_cur    = '0;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .busy    (busy),
    .TXD     (TXD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level for frame bit k: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst, input logic we, input logic [7:0] wd);
    bit full_pre;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_off    = 0;
    end else begin
      full_pre = (mq.size() == FD);
      if (m_active) begin
        if (m_off == FRAME - 1) m_active = 1'b0;
        else m_off++;
      end
      if (!m_active && mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_off    = 0;
      end
      if (we && !full_pre) mq.push_back(wd);
    end
  endtask

  task automatic tick(input logic rst, input logic we, input logic [7:0] wd);
    RESET   = rst;
    wr_en   = we;
    wr_data = wd;
    @(posedge CLK);
    model_edge(rst, we, wd);
    #1;
    check("txd",  TXD,  m_active ? frame_bit(m_cur, m_off / CPB) : 1'b1);
    check("busy", busy, (m_active || mq.size() != 0) ? 1'b1 : 1'b0);
    check("full", full, (mq.size() == FD) ? 1'b1 : 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int unsigned lat;
    int unsigned rate;
    RESET   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;

    // Reset, including a write that must be discarded.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hAA);
    check("rst_txd",  TXD,  1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    idle(5);

    // Single byte: start bit two cycles after the write edge.
    tick(1'b0, 1'b1, 8'h55);
    lat = 1;
    while (TXD !== 1'b0 && lat < 10) begin
      tick(1'b0, 1'b0, 8'h00);
      lat++;
    end
    check("start_latency", lat, 2);
    idle(FRAME + 5);
    check("single_done_busy", busy, 1'b0);

    // Back-to-back frames.
    tick(1'b0, 1'b1, 8'h41);
    tick(1'b0, 1'b1, 8'h42);
    idle(2 * FRAME + 5);

    // Overflow: six consecutive writes into a depth-4 FIFO.
    for (int unsigned i = 1; i <= 6; i++) tick(1'b0, 1'b1, 8'(i));
    check("ovf_full", full, 1'b1);
    idle(6 * FRAME);

    // Continuous writes keep the FIFO full across frame-end pops.
    for (int unsigned i = 0; i < 2 * FRAME + 10; i++) tick(1'b0, 1'b1, 8'(8'h80 + i));
    idle(6 * FRAME);

    // Reset during data bit 3 of 0xF0, then a clean frame of 0x0F.
    tick(1'b0, 1'b1, 8'hF0);
    idle(1 + 4 * CPB + 1);
    tick(1'b1, 1'b0, 8'h00);
    check("midrst_txd",  TXD,  1'b1);
    check("midrst_busy", busy, 1'b0);
    tick(1'b0, 1'b1, 8'h0F);
    idle(FRAME + 5);

    // Idle line.
    for (int unsigned i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      check("idle_txd",  TXD,  1'b1);
      check("idle_busy", busy, 1'b0);
    end

    // Randomized traffic at varying write rates with rare resets.
    for (int unsigned blk = 0; blk < 6; blk++) begin
      case (blk % 3)
        0:       rate = 3;
        1:       rate = 12;
        default: rate = 60;
      endcase
      for (int unsigned i = 0; i < 500; i++) begin
        tick(($urandom_range(0, 699) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0,
             8'($urandom));
      end
    end
    idle(6 * FRAME);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 20, which sets the number of CLK cycles per serial bit; legal values are 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, which sets the number of byte entries; legal values are powers of two, 2 or more.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: byte write strobe from the SOC store path.
REQ-006 SHALL have port wr_data, input, 8 bits: byte to transmit, sampled when wr_en=1.
REQ-007 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH entries; registered.
REQ-008 SHALL have port busy, output, 1 bit: frame in progress or FIFO non-empty; registered.
REQ-009 SHALL have port TXD, output, 1 bit: serial line, idle high; registered.

Function
REQ-010 SHALL enqueue wr_data on any edge where wr_en=1 and full=0.
REQ-011 SHALL silently drop a write when full=1, even if a pop occurs in the same cycle; count and contents stay unchanged.
REQ-012 SHALL, on a simultaneous write and pop with 0<count<FIFO_DEPTH, keep count unchanged and preserve FIFO order.
REQ-013 SHALL wrap read and write pointers modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE->START transition: on an edge where the FIFO is non-empty; that edge pops the head byte into the shift register.
REQ-016 On entry to START, TXD SHALL be 0 in the cycle after the pop.
REQ-017 A byte written into an empty FIFO while IDLE SHALL therefore give TXD=0 two cycles after the wr_en edge.
REQ-018 SHALL hold each state bit for exactly CLKS_PER_BIT cycles using a down-counter reloaded with CLKS_PER_BIT-1; the counter advances state at 0.
REQ-019 DATA SHALL send 8 bits LSB first, tracked by a 3-bit index; DATA->STOP after index 7 completes.
REQ-020 STOP SHALL drive TXD=1 for CLKS_PER_BIT cycles.
REQ-021 At the end of STOP, SHALL go to START if the FIFO is non-empty, popping on that edge so no idle bit is inserted; otherwise SHALL go to IDLE.
REQ-022 A frame SHALL last exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be contiguous.
REQ-023 busy SHALL be 1 whenever state!=IDLE or count!=0, and 0 only when both are idle and empty.
REQ-024 A write arriving during the last STOP cycle SHALL be treated as non-empty on the following edge, not on the same edge.

Reset
REQ-025 SHALL, while RESET=1 at an edge, set state=IDLE, TXD=1, full=0, busy=0, pointers=0, count=0, and bit counter=0.
REQ-026 RESET SHALL have priority over wr_en; writes during reset are discarded.
REQ-027 Reset mid-frame SHALL abort the frame, drive TXD=1 from the next cycle, and lose all queued bytes.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, FRAME_BITS=10, and DATA_BITS=8.
REQ-029 The FIFO SHALL be a sub-module sync_fifo with push/pop/full/empty/count; the FSM and baud counter stay in uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Single byte: write 0x55 when idle -> TXD=0 two cycles later, then bits 1,0,1,0,1,0,1,0 then 1, each 4 cycles; busy drops after 40 cycles.
REQ-031 Back-to-back: write 0x41 then 0x42 on consecutive cycles -> two contiguous 40-cycle frames, no idle gap, LSB first.
REQ-032 Overflow: write 6 bytes 0x01..0x06 on consecutive cycles -> full=1 once four bytes are queued, dropped write(s) never appear, and the transmitted sequence is a gap-free prefix of the written order.
REQ-033 Full with pop: write on the same edge the FSM pops while full=1 -> byte dropped and count becomes FIFO_DEPTH-1.
REQ-034 Reset mid-frame: assert RESET during DATA bit 3 of 0xF0 -> TXD=1 next cycle, busy=0, and a subsequent write of 0x0F transmits correctly.
REQ-035 Idle line: 100 cycles with no writes -> TXD held at 1 and busy=0 throughout.
